// File: rtl/aes_out_pkg.sv
// aes_out_pkg: shared constants, FSM state type and word-select helper for the AES output serializer
package aes_out_pkg;
  localparam int BLK_W    = 128;
  localparam int WORD_CNT = BLK_W / 32;
  typedef enum logic {IDLE, SEND} state_e;
  function automatic logic [BLK_W-1:0] shift_word(input logic [BLK_W-1:0] blk, input int w);
    return blk << w;
  endfunction
endpackage

// File: rtl/aes_blk_fifo.sv
// aes_blk_fifo: 128-bit x DEPTH synchronous block FIFO exposing head and the entry behind it
module aes_blk_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [127:0]             wdata_i,
  input  logic                     pop_i,
  output logic [127:0]             head_o,
  output logic [127:0]             next_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [127:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q, rd_nxt;
  logic [LW-1:0] level_q;
  logic          acc_push, acc_pop;
  assign full_o   = level_q == LW'(DEPTH);
  assign empty_o  = level_q == '0;
  assign acc_push = push_i && (!full_o || pop_i);
  assign acc_pop  = pop_i && !empty_o;
  assign rd_nxt   = rd_q + 1'b1;
  assign head_o   = mem_q[rd_q];
  assign next_o   = mem_q[rd_nxt];
  assign level_o  = level_q;
  // storage write on every accepted push
  always_ff @(posedge clk) begin
    if (acc_push) mem_q[wr_q] <= wdata_i;
  end
  // pointers wrap naturally; level carries the extra bit that separates full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (acc_push) wr_q <= wr_q + 1'b1;
      if (acc_pop) rd_q <= rd_nxt;
      level_q <= level_q + LW'(acc_push) - LW'(acc_pop);
    end
  end
endmodule

// File: rtl/aes_out_serializer.sv
// aes_out_serializer: queues 128-bit AES blocks and streams them MS word first; AES_OUT_EDGE_CAPTURE_EN selects rising-edge capture
module aes_out_serializer
  import aes_out_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                   AES_clk,
  input  logic                   AES_rst,
  input  logic                   blk_in_valid,
  input  logic [127:0]           blk_in_data,
  output logic                   word_out_valid,
  input  logic                   word_out_ready,
  output logic [WORD_W-1:0]      word_out_data,
  output logic                   word_out_last,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);
  localparam int WCNT = BLK_W / WORD_W;
  localparam int KW   = (WCNT > 1) ? $clog2(WCNT) : 1;
  localparam int LW   = $clog2(DEPTH) + 1;
  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [127:0]  out_q, out_d;
  logic [127:0]  head, nxt, nxt_blk;
  logic [LW-1:0] level;
  logic          push_req, pop, full, empty, has_next, last_k, ovf_q;
`ifdef AES_OUT_EDGE_CAPTURE_EN
  logic prev_q;
  // previous valid, so a held valid yields a single push
  always_ff @(posedge AES_clk) begin
    prev_q <= AES_rst ? 1'b0 : blk_in_valid;
  end
  assign push_req = blk_in_valid && !prev_q;
`else
  assign push_req = blk_in_valid;
`endif
  aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (AES_clk),
    .rst     (AES_rst),
    .push_i  (push_req),
    .wdata_i (blk_in_data),
    .pop_i   (pop),
    .head_o  (head),
    .next_o  (nxt),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );
  assign last_k   = k_q == KW'(WCNT - 1);
  assign has_next = (level > LW'(1)) || push_req;
  assign nxt_blk  = (level > LW'(1)) ? nxt : blk_in_data;
  // next-state: load a head block, shift one word per handshake, chain the next block without a bubble
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    out_d   = out_q;
    pop     = 1'b0;
    if (state_q == IDLE) begin
      if (!empty) begin
        state_d = SEND;
        k_d     = '0;
        out_d   = head;
      end
    end else if (word_out_ready) begin
      pop     = last_k;
      k_d     = last_k ? '0 : k_q + 1'b1;
      state_d = (last_k && !has_next) ? IDLE : SEND;
      out_d   = (last_k && has_next) ? nxt_blk : shift_word(out_q, WORD_W);
    end
  end
  // FSM, word counter and output shift register
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      out_q   <= out_d;
    end
  end
  // sticky drop flag: push while full with no pop in the same cycle
  always_ff @(posedge AES_clk) begin
    ovf_q <= AES_rst ? 1'b0 : (ovf_q || (push_req && full && !pop));
  end
  assign word_out_valid = state_q == SEND;
  assign word_out_data  = out_q[127 -: WORD_W];
  assign word_out_last  = word_out_valid && last_k;
  assign fifo_level     = level;
  assign overflow       = ovf_q;
endmodule

// File: tb/tb_aes_out_serializer.sv
// tb_aes_out_serializer: directed table and sequence checks for aes_out_serializer (DEPTH=8, WORD_W=32)
module tb_aes_out_serializer;
  localparam int DEPTH = 8;
  logic         AES_clk = 1'b0;
  logic         AES_rst = 1'b1;
  logic         blk_in_valid = 1'b0;
  logic [127:0] blk_in_data = '0;
  logic         word_out_ready = 1'b0;
  logic         word_out_valid, word_out_last, overflow;
  logic [31:0]  word_out_data;
  logic [3:0]   fifo_level;
  int n_run = 0;
  int n_fail = 0;

  aes_out_serializer #(.DEPTH(DEPTH), .WORD_W(32)) dut (
    .AES_clk        (AES_clk),
    .AES_rst        (AES_rst),
    .blk_in_valid   (blk_in_valid),
    .blk_in_data    (blk_in_data),
    .word_out_valid (word_out_valid),
    .word_out_ready (word_out_ready),
    .word_out_data  (word_out_data),
    .word_out_last  (word_out_last),
    .fifo_level     (fifo_level),
    .overflow       (overflow)
  );

  always #5 AES_clk = ~AES_clk;

  typedef struct {
    logic         push;
    logic [127:0] blk;
    logic         ready;
    logic         exp_valid;
    logic [31:0]  exp_data;
    logic         exp_last;
    logic [3:0]   exp_level;
  } vec_t;

  vec_t tv [18];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge AES_clk);
    #1;
  endtask

  function automatic logic [127:0] mk(input int i);
    logic [15:0] t;
    t = 16'hB000 + 16'(i);
    return {t, 16'd0, t, 16'd1, t, 16'd2, t, 16'd3};
  endfunction

  task automatic push_blk(input logic [127:0] b);
    blk_in_valid = 1'b1;
    blk_in_data  = b;
    tick();
    blk_in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, word_out_valid, 0);
    chk({tag, " data"}, word_out_data, 0);
    chk({tag, " last"}, word_out_last, 0);
    chk({tag, " level"}, fifo_level, 0);
    chk({tag, " overflow"}, overflow, 0);
  endtask

  task automatic drain(input int first, input int nblk, input bit bp, input bit same, input string tag);
    int hs;
    int total;
    logic [127:0] b;
    hs = 0;
    total = nblk * 4;
    for (int c = 0; c < total * 3 + 20 && hs < total; c++) begin
      word_out_ready = bp ? (c % 3 == 0) : 1'b1;
      if (word_out_valid) begin
        b = mk(same ? first : first + hs / 4);
        chk({tag, " data"}, word_out_data, b[127 - (hs % 4) * 32 -: 32]);
        chk({tag, " last"}, word_out_last, (hs % 4) == 3);
        if (word_out_ready) hs++;
      end
      tick();
    end
    word_out_ready = 1'b0;
    chk({tag, " handshakes"}, hs, total);
  endtask

  initial begin
    logic [127:0] a, b, c, t;
    a = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
    b = 128'hd7b26248_e8351227_5573a1e5_e8f263b3;
    c = 128'hf301a68a_9e9ffa50_844581d9_e290d818;
    tv[0]  = '{1'b1, a, 1'b1, 1'b0, 32'h0,        1'b0, 4'd0};
    tv[1]  = '{1'b0, 0, 1'b1, 1'b0, 32'h0,        1'b0, 4'd1};
    tv[2]  = '{1'b0, 0, 1'b1, 1'b1, 32'ha6f2daeb, 1'b0, 4'd1};
    tv[3]  = '{1'b0, 0, 1'b1, 1'b1, 32'h140fa720, 1'b0, 4'd1};
    tv[4]  = '{1'b0, 0, 1'b1, 1'b1, 32'h529e75d5, 1'b0, 4'd1};
    tv[5]  = '{1'b0, 0, 1'b1, 1'b1, 32'h21cbc681, 1'b1, 4'd1};
    tv[6]  = '{1'b0, 0, 1'b1, 1'b0, 32'h0,        1'b0, 4'd0};
    tv[7]  = '{1'b1, b, 1'b1, 1'b0, 32'h0,        1'b0, 4'd0};
    tv[8]  = '{1'b1, c, 1'b1, 1'b0, 32'h0,        1'b0, 4'd1};
    tv[9]  = '{1'b0, 0, 1'b1, 1'b1, 32'hd7b26248, 1'b0, 4'd2};
    tv[10] = '{1'b0, 0, 1'b1, 1'b1, 32'he8351227, 1'b0, 4'd2};
    tv[11] = '{1'b0, 0, 1'b1, 1'b1, 32'h5573a1e5, 1'b0, 4'd2};
    tv[12] = '{1'b0, 0, 1'b1, 1'b1, 32'he8f263b3, 1'b1, 4'd2};
    tv[13] = '{1'b0, 0, 1'b1, 1'b1, 32'hf301a68a, 1'b0, 4'd1};
    tv[14] = '{1'b0, 0, 1'b1, 1'b1, 32'h9e9ffa50, 1'b0, 4'd1};
    tv[15] = '{1'b0, 0, 1'b1, 1'b1, 32'h844581d9, 1'b0, 4'd1};
    tv[16] = '{1'b0, 0, 1'b1, 1'b1, 32'he290d818, 1'b1, 4'd1};
    tv[17] = '{1'b0, 0, 1'b1, 1'b0, 32'h0,        1'b0, 4'd0};

    repeat (3) tick();
    chk_idle("reset");
    AES_rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      blk_in_valid   = tv[i].push;
      blk_in_data    = tv[i].blk;
      word_out_ready = tv[i].ready;
      chk($sformatf("tv%0d valid", i), word_out_valid, tv[i].exp_valid);
      chk($sformatf("tv%0d data", i), word_out_data, tv[i].exp_data);
      chk($sformatf("tv%0d last", i), word_out_last, tv[i].exp_last);
      chk($sformatf("tv%0d level", i), fifo_level, tv[i].exp_level);
      tick();
    end
    blk_in_valid   = 1'b0;
    word_out_ready = 1'b0;

    push_blk(mk(1));
    drain(1, 1, 1'b1, 1'b0, "backpressure");
    chk("backpressure idle", word_out_valid, 0);

    push_blk(mk(2));
    push_blk(mk(3));
    word_out_ready = 1'b1;
    tick();
    tick();
    t = mk(2);
    chk("midsend data", word_out_data, t[63:32]);
    AES_rst = 1'b1;
    word_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("midreset");
    end
    AES_rst = 1'b0;
    push_blk(mk(4));
    tick();
    t = mk(4);
    chk("restart valid", word_out_valid, 1);
    chk("restart data", word_out_data, t[127:96]);
    chk("restart last", word_out_last, 0);
    chk("restart level", fifo_level, 1);
    drain(4, 1, 1'b0, 1'b0, "restart");
    chk("restart level end", fifo_level, 0);

    for (int i = 0; i <= DEPTH; i++) push_blk(mk(10 + i));
    chk("ovf level", fifo_level, DEPTH);
    chk("ovf flag", overflow, 1);
    drain(10, DEPTH, 1'b0, 1'b0, "ovf drain");
    tick();
    chk("ovf dropped valid", word_out_valid, 0);
    chk("ovf dropped level", fifo_level, 0);
    chk("ovf sticky", overflow, 1);

    AES_rst = 1'b1;
    tick();
    AES_rst = 1'b0;
    chk("ovf cleared", overflow, 0);
    for (int i = 0; i < DEPTH; i++) push_blk(mk(30 + i));
    chk("full level", fifo_level, DEPTH);
    word_out_ready = 1'b1;
    repeat (3) tick();
    chk("full last", word_out_last, 1);
    blk_in_valid = 1'b1;
    blk_in_data  = mk(40);
    tick();
    blk_in_valid   = 1'b0;
    word_out_ready = 1'b0;
    t = mk(31);
    chk("pushpop level", fifo_level, DEPTH);
    chk("pushpop overflow", overflow, 0);
    chk("pushpop data", word_out_data, t[127:96]);
    drain(31, DEPTH - 1, 1'b0, 1'b0, "pushpop drain");
    drain(40, 1, 1'b0, 1'b0, "pushpop tail");

    AES_rst = 1'b1;
    tick();
    AES_rst = 1'b0;
    blk_in_valid = 1'b1;
    blk_in_data  = mk(50);
    repeat (5) tick();
    blk_in_valid = 1'b0;
`ifdef AES_OUT_EDGE_CAPTURE_EN
    chk("held valid level", fifo_level, 1);
    drain(50, 1, 1'b0, 1'b1, "held drain");
`else
    chk("held valid level", fifo_level, 5);
    drain(50, 5, 1'b0, 1'b1, "held drain");
`endif
    tick();
    chk("held end valid", word_out_valid, 0);
    chk("held end level", fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
